// File: rtl/cv32e40s_register_file_scrub_if.sv
// Read/write port bundle of the parity-protected register file.
// The core side (master) drives addresses and write data; the register file (slave) returns read data.
interface cv32e40s_register_file_scrub_if #(
  parameter int NUM_WORDS       = 32,
  parameter int DATA_W          = 32,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2,
  localparam int AW             = $clog2(NUM_WORDS)
);
  logic [NUM_READ_PORTS-1:0][AW-1:0]      raddr_i;
  logic [NUM_READ_PORTS-1:0][DATA_W-1:0]  rdata_o;
  logic [NUM_READ_PORTS-1:0]              rerr_o;
  logic [NUM_WRITE_PORTS-1:0][AW-1:0]     waddr_i;
  logic [NUM_WRITE_PORTS-1:0][DATA_W-1:0] wdata_i;
  logic [NUM_WRITE_PORTS-1:0]             we_i;

  modport master (output raddr_i, waddr_i, wdata_i, we_i, input rdata_o, rerr_o);
  modport slave  (input raddr_i, waddr_i, wdata_i, we_i, output rdata_o, rerr_o);
endinterface

// File: rtl/cv32e40s_register_file_scrub.sv
// Flip-flop register file with per-byte odd parity, combinational reads and a
// background scrubber that periodically re-checks every writable word.
module cv32e40s_register_file_scrub #(
  parameter int NUM_WORDS       = 32,
  parameter int DATA_W          = 32,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int ZERO_REG        = 1,
  parameter int BYPASS          = 0,
  parameter int SCRUB_INTERVAL  = 8,
  localparam int AW             = $clog2(NUM_WORDS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  cv32e40s_register_file_scrub_if.slave       rf,
  input  logic                                scrub_en_i,
  output logic                                scrub_busy_o,
  output logic                                err_alert_o,
  output logic [AW-1:0]                       err_addr_o,
  output logic [7:0]                          err_cnt_o,
  input  logic                                err_clr_i,
  input  logic                                inj_we_i,
  input  logic [AW-1:0]                       inj_addr_i
);

  localparam int P  = DATA_W / 8;
  localparam int CW = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [AW-1:0] FIRST_WORD = (ZERO_REG != 0) ? AW'(1) : '0;

  typedef struct packed {
    logic [P-1:0]      par;
    logic [DATA_W-1:0] data;
  } word_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK} state_e;

  localparam word_t RESET_WORD = '{par: '1, data: '0};

  function automatic logic [P-1:0] odd_par(input logic [DATA_W-1:0] d);
    logic [P-1:0] p;
    for (int b = 0; b < P; b++) p[b] = ~^d[8*b +: 8];
    return p;
  endfunction

  function automatic logic word_bad(input word_t w);
    return w.par != odd_par(w.data);
  endfunction

  // Real storage: in range and not the hard-wired zero register.
  function automatic logic is_storage(input logic [AW-1:0] a);
    return (32'(a) < NUM_WORDS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  word_t                 mem_q [NUM_WORDS];
  word_t                 mem_d [NUM_WORDS];
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic                  alert_q, alert_d;
  logic [AW-1:0]         err_addr_q, err_addr_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic [NUM_READ_PORTS-1:0][DATA_W-1:0] rdata;
  logic [NUM_READ_PORTS-1:0]             rerr;
  logic [7:0]            cnt_base;

  // Injection first, then writes in ascending port order: a write beats injection, the highest port wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latches are inferred.
    mem_d = mem_q;
    if (inj_we_i && is_storage(inj_addr_i)) begin
      mem_d[inj_addr_i].par[0] = ~mem_q[inj_addr_i].par[0];
    end
    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
      if (rf.we_i[w] && is_storage(rf.waddr_i[w])) begin
        mem_d[rf.waddr_i[w]] = '{par: odd_par(rf.wdata_i[w]), data: rf.wdata_i[w]};
      end
    end
  end

  always_comb begin
    rdata = '0;
    rerr  = '0;
    for (int r = 0; r < NUM_READ_PORTS; r++) begin
      if (is_storage(rf.raddr_i[r])) begin
        rdata[r] = mem_q[rf.raddr_i[r]].data;
        rerr[r]  = word_bad(mem_q[rf.raddr_i[r]]);
      end
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
          if (rf.we_i[w] && is_storage(rf.waddr_i[w]) && (rf.waddr_i[w] == rf.raddr_i[r])) begin
            rdata[r] = rf.wdata_i[w];
            rerr[r]  = 1'b0;
          end
        end
      end
    end
  end

  assign rf.rdata_o = rdata;
  assign rf.rerr_o  = rerr;

  // A clear coincident with a new fault restarts the count from the fault.
  assign cnt_base = err_clr_i ? 8'd0 : err_cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    alert_d    = 1'b0;
    err_addr_d = err_clr_i ? '0 : err_addr_q;
    err_cnt_d  = cnt_base;
    if (!scrub_en_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: begin
          if (cnt_q == CW'(SCRUB_INTERVAL - 1)) state_d = S_CHECK;
          else                                  cnt_d   = cnt_q + CW'(1);
        end
        S_CHECK: begin
          if (word_bad(mem_q[ptr_q])) begin
            alert_d    = 1'b1;
            err_addr_d = ptr_q;
            err_cnt_d  = (cnt_base == 8'hFF) ? cnt_base : cnt_base + 8'd1;
          end
          ptr_d   = (32'(ptr_q) == NUM_WORDS - 1) ? FIRST_WORD : ptr_q + AW'(1);
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage array is reset on purpose; a word must never read back with bad parity after reset.
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= RESET_WORD;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= FIRST_WORD;
      alert_q    <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= mem_d[i];
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      alert_q    <= alert_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign scrub_busy_o = (state_q != S_IDLE);
  assign err_alert_o  = alert_q;
  assign err_addr_o   = err_addr_q;
  assign err_cnt_o    = err_cnt_q;

endmodule
